// File: rtl/byte_frame_parser.sv
// byte_frame_parser: hunts for a sync byte, reads a length byte, collects the
// payload into a small FIFO and checks the trailing checksum byte. The payload
// is presented on a valid/ready stream with an end-of-frame tag. Per-frame
// pass/fail pulses and wrapping good/bad frame counters are also provided.
module byte_frame_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         DEPTH     = 16,
  parameter int         CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_frame_ok,
  output logic             o_frame_err,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_good_cnt,
  output logic [CNT_W-1:0] o_bad_cnt
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_remaining;
  logic [7:0]       r_sum;
  logic             r_frame_ovf;

  logic [8:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             r_frame_ok;
  logic             r_frame_err;
  logic             r_overflow;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_bad_cnt;

  logic             w_full;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_len_bad;
  logic             w_csum_ok;
  logic             w_csum_bad;

  // Fullness is judged on the count before this cycle, ignoring a same-cycle pop.
  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && i_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-byte control strobes; only valid bytes advance.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_len_bad   = 1'b0;
    w_csum_ok   = 1'b0;
    w_csum_bad  = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (i_valid && (i_data == SYNC_BYTE)) begin
          w_state_nxt = S_LEN;
        end else begin
          w_state_nxt = S_HUNT;
        end
      end
      S_LEN: begin
        if (i_valid) begin
          if ((i_data == 8'd0) || (i_data > MAX_LEN_B)) begin
            w_len_bad   = 1'b1;
            w_state_nxt = S_HUNT;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_LEN;
        end
      end
      S_DATA: begin
        if (i_valid) begin
          if (w_full) begin
            w_drop = 1'b1;
          end else begin
            w_push = 1'b1;
          end
          if (r_remaining == 8'd1) begin
            w_state_nxt = S_CSUM;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_CSUM: begin
        if (i_valid) begin
          if ((i_data == r_sum) && !r_frame_ovf) begin
            w_csum_ok = 1'b1;
          end else begin
            w_csum_bad = 1'b1;
          end
          w_state_nxt = S_HUNT;
        end else begin
          w_state_nxt = S_CSUM;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
  end

  // Frame bookkeeping: remaining byte count, running checksum, overflow-in-frame flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_remaining <= 8'd0;
      r_sum       <= 8'd0;
      r_frame_ovf <= 1'b0;
    end else begin
      if ((r_state == S_LEN) && i_valid) begin
        r_remaining <= i_data;
        r_sum       <= i_data;
      end else if ((r_state == S_DATA) && i_valid) begin
        r_remaining <= r_remaining - 8'd1;
        r_sum       <= r_sum + i_data;
      end else begin
        r_remaining <= r_remaining;
        r_sum       <= r_sum;
      end
      if (w_drop) begin
        r_frame_ovf <= 1'b1;
      end else if (w_csum_ok || w_csum_bad) begin
        r_frame_ovf <= 1'b0;
      end else begin
        r_frame_ovf <= r_frame_ovf;
      end
    end
  end

  // FIFO storage; contents need no reset because the count gates the head.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {(r_remaining == 8'd1), i_data};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame result pulses, sticky overflow and wrapping frame counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
    end else begin
      r_frame_ok  <= w_csum_ok;
      r_frame_err <= w_len_bad || w_csum_bad;
      r_overflow  <= r_overflow || w_drop;
      if (w_csum_ok) begin
        r_good_cnt <= r_good_cnt + 1'b1;
      end
      if (w_len_bad || w_csum_bad) begin
        r_bad_cnt <= r_bad_cnt + 1'b1;
      end
    end
  end

  assign o_valid     = w_valid;
  assign o_data      = w_valid ? r_mem[r_rd_ptr][7:0] : 8'd0;
  assign o_last      = w_valid ? r_mem[r_rd_ptr][8]   : 1'b0;
  assign o_frame_ok  = r_frame_ok;
  assign o_frame_err = r_frame_err;
  assign o_overflow  = r_overflow;
  assign o_good_cnt  = r_good_cnt;
  assign o_bad_cnt   = r_bad_cnt;

endmodule

// File: tb/tb_byte_frame_parser.sv
// Directed bench for byte_frame_parser: a per-cycle vector table with
// hand-computed expected outputs, plus a backpressure sequence checked
// against an in-order reference list.
module tb_byte_frame_parser;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic        o_frame_ok;
  logic        o_frame_err;
  logic        o_overflow;
  logic [15:0] o_good_cnt;
  logic [15:0] o_bad_cnt;

  byte_frame_parser dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_last      (o_last),
    .i_ready     (i_ready),
    .o_frame_ok  (o_frame_ok),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow),
    .o_good_cnt  (o_good_cnt),
    .o_bad_cnt   (o_bad_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        eok;
    logic        eerr;
    logic        eovf;
    logic [15:0] eg;
    logic [15:0] eb;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_g = 16'd0;
  logic [15:0] exp_b = 16'd0;
  logic        exp_ovf = 1'b0;

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic rd,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic eok, input logic eerr);
    vec_t t;
    t.rst_n = r;  t.vld = v;  t.dat = d;  t.rdy = rd;
    t.ev = ev;    t.ed = ed;  t.el = el;  t.eok = eok; t.eerr = eerr;
    t.eovf = exp_ovf; t.eg = exp_g; t.eb = exp_b;
    vecs.push_back(t);
  endtask

  // Good frame A5 03 11 22 33 69 with i_ready high; an i_valid=0 byte is ignored.
  task automatic add_good_frame();
    add(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    exp_g = exp_g + 16'd1;
    add(1'b1, 1'b1, 8'h69, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] bp_in [6];
    logic [7:0] bp_exp [3];
    int         idx;
    int         pops;
    int         ok_seen;
    logic       held_v;
    logic [7:0] held_d;
    logic       held_l;

    // Reset state.
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add_good_frame();

    // Bad checksum: 02+10+20 = 32, sent 31.
    add(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    exp_b = 16'd1;
    add(1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Hunt noise, zero length, oversize length, then a one-byte good frame.
    add(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_b = 16'd2;
    add(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_b = 16'd3;
    add(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    exp_g = 16'd2;
    add(1'b1, 1'b1, 8'h43, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Fill the FIFO exactly with i_ready low: 16 bytes 01..10, checksum 10+88 = 98.
    add(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      add(1'b1, 1'b1, 8'(k), 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    end
    exp_g = 16'd3;
    add(1'b1, 1'b1, 8'h98, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    // Second frame while full: byte 07 dropped, checksum matches but frame fails.
    add(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    exp_ovf = 1'b1;
    add(1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    exp_b = 16'd4;
    add(1'b1, 1'b1, 8'h08, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    // Drain: head walks 02..10, last tag only on 10.
    for (int k = 2; k <= 16; k++) begin
      add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'(k), (k == 16), 1'b0, 1'b0);
    end
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame, then a full good frame.
    add(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    exp_g = 16'd0; exp_b = 16'd0; exp_ovf = 1'b0;
    add(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add_good_frame();

    // Apply the table: drive, clock, check just after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      i_reset = vecs[i].rst_n;
      i_valid = vecs[i].vld;
      i_data  = vecs[i].dat;
      i_ready = vecs[i].rdy;
      @(posedge i_clk);
      #1;
      total++;
      if (o_valid !== vecs[i].ev || o_data !== vecs[i].ed || o_last !== vecs[i].el ||
          o_frame_ok !== vecs[i].eok || o_frame_err !== vecs[i].eerr ||
          o_overflow !== vecs[i].eovf || o_good_cnt !== vecs[i].eg || o_bad_cnt !== vecs[i].eb) begin
        bad++;
        $display("FAIL vec%0d got v=%b d=%h l=%b ok=%b err=%b ovf=%b g=%0d b=%0d want v=%b d=%h l=%b ok=%b err=%b ovf=%b g=%0d b=%0d",
                 i, o_valid, o_data, o_last, o_frame_ok, o_frame_err, o_overflow, o_good_cnt, o_bad_cnt,
                 vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eok, vecs[i].eerr, vecs[i].eovf,
                 vecs[i].eg, vecs[i].eb);
      end
    end

    // Backpressure: random i_ready and input gaps during a good frame.
    bp_in[0] = 8'hA5; bp_in[1] = 8'h03; bp_in[2] = 8'h11;
    bp_in[3] = 8'h22; bp_in[4] = 8'h33; bp_in[5] = 8'h69;
    bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33;
    idx = 0; pops = 0; ok_seen = 0; held_v = 1'b0; held_d = 8'h00; held_l = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (held_v) begin
        total++;
        if (!(o_valid === 1'b1 && o_data === held_d && o_last === held_l)) begin
          bad++;
          $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b", o_valid, o_data, o_last, held_d, held_l);
        end
      end
      i_ready = 1'($urandom_range(0, 1));
      if (idx < 6 && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b1; i_data = bp_in[idx]; idx++;
      end else begin
        i_valid = 1'b0; i_data = 8'h00;
      end
      if (o_valid && i_ready) begin
        total++;
        if (pops >= 3) begin
          bad++;
          $display("FAIL bp_extra got d=%h want no more bytes", o_data);
        end else if (o_data !== bp_exp[pops] || o_last !== (pops == 2)) begin
          bad++;
          $display("FAIL bp_pop%0d got d=%h l=%b want d=%h l=%b", pops, o_data, o_last, bp_exp[pops], (pops == 2));
        end
        pops++;
      end
      held_v = o_valid && !i_ready;
      held_d = o_data;
      held_l = o_last;
      @(posedge i_clk);
      #1;
      if (o_frame_ok) ok_seen++;
    end
    total++;
    if (pops != 3 || ok_seen != 1 || o_good_cnt !== 16'd2 || o_bad_cnt !== 16'd0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_summary got pops=%0d ok=%0d g=%0d b=%0d v=%b want pops=3 ok=1 g=2 b=0 v=0",
               pops, ok_seen, o_good_cnt, o_bad_cnt, o_valid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_frame_parser.md
Name: byte_frame_parser

Overview:
- Downstream consumer of the registered 8-bit data stream in the i_clk domain.
- Hunts for a sync byte, reads a length byte, collects the payload bytes and checks a trailing checksum byte.
- Buffers payload bytes in a small FIFO and presents them on a valid/ready stream with an end-of-frame marker.
- Reports per-frame pass/fail and keeps running good/bad frame counters.

Parameters:
- SYNC_BYTE, 8'hA5, frame start delimiter.
- MAX_LEN, 16, largest legal payload length; LEN > MAX_LEN is an error.
- DEPTH, 16, payload FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the frame counters.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  input byte qualifier; no backpressure to upstream.
- i_data  in  8  input byte.
- o_valid  out  1  payload byte available.
- o_data  out  8  payload byte at FIFO head.
- o_last  out  1  head byte is the last payload byte of its frame.
- i_ready  in  1  downstream accepts; pop when o_valid && i_ready.
- o_frame_ok  out  1  one-cycle pulse: checksum matched, no overflow.
- o_frame_err  out  1  one-cycle pulse: bad length, bad checksum or overflow in frame.
- o_overflow  out  1  sticky: a payload byte was dropped because the FIFO was full.
- o_good_cnt  out  CNT_W  frames ended with o_frame_ok; wraps.
- o_bad_cnt  out  CNT_W  frames ended with o_frame_err; wraps.

Behaviour:
- Reset: the reset is i_reset, synchronous, active-low; the clock is i_clk.
  - While i_reset is low at a posedge: FSM goes to HUNT, FIFO is emptied, and a running frame is abandoned without a pulse.
  - All outputs are 0 during and after reset: o_valid, o_data, o_last, o_frame_ok, o_frame_err, o_overflow, both counters.
- The FSM advances only on cycles with i_valid = 1. Bytes with i_valid = 0 are ignored.
- HUNT: byte == SYNC_BYTE -> LEN. Any other byte is discarded and the FSM stays in HUNT.
- LEN: the byte is latched as the remaining count, and the sum register is set to the byte.
  - Byte == 0 or > MAX_LEN -> o_frame_err pulse, o_bad_cnt+1, back to HUNT.
  - Otherwise -> DATA.
- DATA: the sum register accumulates the byte, mod 256.
  - The byte is pushed to the FIFO with tag last = (remaining == 1).
  - The FIFO is full when count == DEPTH before this cycle, regardless of a simultaneous pop. A byte arriving when full is dropped, o_overflow is set, and the frame-overflow flag is set.
  - remaining decrements; at 1 -> CSUM.
- CSUM:
  - Byte == sum and frame-overflow flag clear -> o_frame_ok pulse, o_good_cnt+1.
  - Otherwise -> o_frame_err pulse, o_bad_cnt+1.
  - Pulses and counters update in the cycle after the CSUM byte is sampled. The frame-overflow flag clears. -> HUNT.
- A sync-valued byte inside LEN, DATA or CSUM is treated as data; there is no resync mid-frame.
- Payload already in the FIFO is delivered even if the frame later fails. Downstream uses o_frame_err to discard it.
- Latency: a payload byte sampled at edge N appears on o_data/o_valid after edge N (registered write, combinational head read). This is 1 cycle if the FIFO was empty.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- Pop when empty cannot occur because o_valid = 0.
- o_data and o_last are held stable while o_valid && !i_ready.
- o_overflow clears only on reset.

Test Plan:
- Good frame: A5 03 11 22 33 69 with i_ready = 1.
  - Response: o_data 11, 22, 33; o_last only on 33; one o_frame_ok; o_good_cnt = 1.
- Bad checksum: A5 02 10 20 31.
  - Response: bytes 10, 20 delivered; o_frame_err; o_bad_cnt = 1; o_good_cnt unchanged.
- Hunt and length: noise 00 FF 5A, then A5 00.
  - Response: no output; o_frame_err after the 00 length byte.
  - Then A5 11 (17 > MAX_LEN): o_frame_err; FSM back in HUNT, and a following good frame is accepted.
- Overflow: i_ready = 0, frame A5 10 followed by 16 bytes 01..10 and a valid checksum 98.
  - Response: all 16 stored, none dropped, o_frame_ok.
  - A second frame A5 01 07 08 with i_ready still 0 drops byte 07: o_overflow = 1, o_frame_err.
- Backpressure: toggle i_ready randomly during the good frame.
  - Response: byte order is preserved, the head is stable while stalled, and there is no loss or duplication.
- Reset mid-frame: drive A5 03 11, then hold i_reset low for 1 cycle.
  - Response: FIFO empty, no pulse, counters 0.
  - A subsequent full good frame parses correctly.
